// File: rtl/dsp_tdm_scheduler_pkg.sv
// Shared constants and helpers for the TDM multiplier scheduler.
// DEFAULT_MULT_LATENCY is also consumed by the multiplier wrapper so both stay aligned.
package tdm_sched_pkg;

    localparam int DEFAULT_MULT_LATENCY = 4;

    // Requester-id width; never zero so a single-bit id always exists.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsp_tdm_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or above ptr, with wrap-around.
// ptr advances past the granted index only on an accept.
module rr_arbiter
    import tdm_sched_pkg::*;
#(
    parameter int N = 2,
    localparam int ID_W = id_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            accept,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N))
                sum = sum - (ID_W+1)'(N);
            idx = sum[ID_W-1:0];
            if (!found && en && rst_n && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == ID_W'(N-1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/dsp_tdm_scheduler.sv
// Shares one pipelined multiplier between NUM_REQ requesters: round-robin accept,
// registered operands, and an id tag pipeline that routes each product back to its owner.
module dsp_tdm_scheduler
    import tdm_sched_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int WIDTH_A      = 8,
    parameter int WIDTH_B      = 8,
    parameter int MULT_LATENCY = DEFAULT_MULT_LATENCY,
    localparam int ID_W = id_width(NUM_REQ),
    localparam int PW   = WIDTH_A + WIDTH_B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [WIDTH_A-1:0] req_a [NUM_REQ],
    input  logic [WIDTH_B-1:0] req_b [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic [WIDTH_A-1:0] mult_a,
    output logic [WIDTH_B-1:0] mult_b,
    input  logic [PW-1:0]      mult_p,
    output logic [NUM_REQ-1:0] res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic [PW-1:0]      res_data,
    output logic               busy
);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0] grant_idx;
    logic            accept;
    // Stage 0 is loaded on the same edge as mult_a/mult_b, so the last stage
    // lines up with mult_p MULT_LATENCY edges later.
    tag_t [MULT_LATENCY:0] tag_pipe;

    assign accept = |(req_valid & req_ready);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req_valid),
        .accept    (accept),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
        end else begin
            tag_pipe[0] <= '{vld: accept, id: grant_idx};
            for (int s = 1; s <= MULT_LATENCY; s++)
                tag_pipe[s] <= tag_pipe[s-1];
            if (accept) begin
                mult_a <= req_a[grant_idx];
                mult_b <= req_b[grant_idx];
            end
        end
    end

    assign res_valid = tag_pipe[MULT_LATENCY].vld
                     ? (NUM_REQ'(1) << tag_pipe[MULT_LATENCY].id) : '0;
    assign res_id    = tag_pipe[MULT_LATENCY].id;
    assign res_data  = mult_p;

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= MULT_LATENCY; s++)
            busy = busy | tag_pipe[s].vld;
    end

endmodule

// File: tb/tb_dsp_tdm_scheduler.sv
// Bench for dsp_tdm_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_dsp_tdm_scheduler;

    localparam int N  = 2;
    localparam int WA = 8;
    localparam int WB = 8;
    localparam int L  = 4;
    localparam int PW = WA + WB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [WA-1:0] req_a [N];
    logic [WB-1:0] req_b [N];
    logic [N-1:0]  req_ready;
    logic [WA-1:0] mult_a;
    logic [WB-1:0] mult_b;
    logic [PW-1:0] mult_p;
    logic [N-1:0]  res_valid;
    logic [0:0]    res_id;
    logic [PW-1:0] res_data;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dsp_tdm_scheduler #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .MULT_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b),
        .mult_p(mult_p), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy)
    );

    // Multiplier stand-in: product of the operands as registered L edges earlier.
    logic [PW-1:0] p_pipe [L];
    always @(posedge clk) begin
        p_pipe[0] <= PW'(mult_a) * PW'(mult_b);
        for (int i = 1; i < L; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign mult_p = p_pipe[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: accepted ops wait in a queue tagged with the cycle they must strobe.
    typedef struct {
        int due;
        int id;
        int prod;
    } exp_t;
    exp_t          q[$];
    int            mptr = 0;
    logic [WA-1:0] ema  = '0;
    logic [WB-1:0] emb  = '0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int o = 0; o < N; o++) begin
            int i = (p + o) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        if (!rst_n) begin
            q.delete();
            mptr = 0; ema = '0; emb = '0;
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_mult_a", 32'(mult_a), 0);
            chk("rst_mult_b", 32'(mult_b), 0);
        end else begin
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("mult_a", 32'(mult_a), 32'(ema));
            chk("mult_b", 32'(mult_b), 32'(emb));
            if (q.size() != 0 && q[0].due == cyc) begin
                chk("res_valid", 32'(res_valid), 32'(1) << q[0].id);
                chk("res_id", 32'(res_id), 32'(q[0].id));
                chk("res_data", 32'(res_data), 32'(q[0].prod));
                void'(q.pop_front());
            end else begin
                chk("res_valid_idle", 32'(res_valid), 0);
            end
            g = en ? pick(req_valid, mptr) : -1;
            chk("req_ready", 32'(req_ready), (g < 0) ? 0 : (32'(1) << g));
            if (g >= 0) begin
                q.push_back('{due: cyc + 1 + L, id: g, prod: int'(req_a[g]) * int'(req_b[g])});
                mptr = (g + 1) % N;
                ema  = req_a[g];
                emb  = req_b[g];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req_valid = '1;
        req_a[0] = 8'd11; req_b[0] = 8'd12; req_a[1] = 8'd13; req_b[1] = 8'd14;
        repeat (3) step();
        #1;
        chk("t1_ready", 32'(req_ready), 0);
        chk("t1_res_valid", 32'(res_valid), 0);
        chk("t1_busy", 32'(busy), 0);

        // Single op from requester 1: 3*5 strobes in the cycle after edge k+L.
        step();
        rst_n = 1'b1; req_valid = 2'b10; req_a[1] = 8'd3; req_b[1] = 8'd5;
        step();                               // accept edge k
        req_valid = '0;
        #1 chk("t2_busy_k", 32'(busy), 1);
        repeat (3) step();
        #1 chk("t2_early", 32'(res_valid), 0);
        step();
        #1;
        chk("t2_valid", 32'(res_valid), 2);
        chk("t2_id", 32'(res_id), 1);
        chk("t2_data", 32'(res_data), 15);
        chk("t2_busy_k4", 32'(busy), 1);
        step();
        #1 chk("t2_busy_off", 32'(busy), 0);

        // Both continuously valid: grants alternate from 0, results back to back.
        req_a[0] = 8'd2; req_b[0] = 8'd7; req_a[1] = 8'd9; req_b[1] = 8'd9;
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_grant", 32'(req_ready), (i % 2) ? 2 : 1);
            if (i >= L + 1) chk("t3_data", 32'(res_data), ((i - L - 1) % 2) ? 81 : 14);
            step();
        end

        // Drop en: ready falls at once, in-flight ops still strobe, busy drains.
        en = 1'b0;
        #1 chk("t4_ready", 32'(req_ready), 0);
        repeat (4) step();
        #1 chk("t4_busy_last", 32'(busy), 1);
        step();
        #1 chk("t4_busy_off", 32'(busy), 0);

        // Reset with ops in flight: none may strobe; requester 0 wins after release.
        en = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        #1 chk("t5_first_grant", 32'(req_ready), 1);
        req_valid = '0;
        for (int i = 0; i < 7; i++) begin
            step();
            #1 chk("t5_no_strobe", 32'(res_valid), 0);
        end

        // Max operands, then pointer follows the last grant, not the last request.
        step();
        req_valid = 2'b01; req_a[0] = 8'd255; req_b[0] = 8'd255;
        step();                               // accept edge k (id 0)
        req_valid = 2'b00;
        step();
        req_valid = 2'b11;
        #1 chk("t6_ptr", 32'(req_ready), 2);
        step();
        req_valid = '0;
        repeat (2) step();
        #1;
        chk("t6_data", 32'(res_data), 65025);
        chk("t6_id", 32'(res_id), 0);
        chk("t6_valid", 32'(res_valid), 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 7) != 0);
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_a[r] = WA'($urandom);
                req_b[r] = WB'($urandom);
            end
        end
        rst_n = 1'b1; req_valid = '0;
        repeat (L + 4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
